theta_phase_sequencer: RTL and testbench

- Transmitter for the theta/gamma phase-code interface: generates the gamma phase counter, the cycle_start pulse and per-gamma-cycle spike timing from an 8-slot programmable phase table.
- The sequencing mirrors the downstream theta-sequence predictors: 256 clocks per gamma cycle, 8 gamma cycles per theta cycle.
- Drives the phase and spike inputs of theta-sequence predictors and phase-coded neurons. Used to replay stored sequences and as a stimulus source.

---
 rtl/theta_phase_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_theta_phase_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/theta_phase_sequencer.sv
// theta_phase_sequencer: theta/gamma phase-code transmitter.
// Replays an 8-slot phase table, one slot per 256-clock gamma cycle, 8 gamma cycles per theta cycle.
module theta_phase_sequencer #(
  parameter logic [7:0] INIT_PHASE = 8'd0,
  parameter logic       INIT_VALID = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_mode,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_phase,
  input  logic       wr_valid,
  output logic [7:0] global_phase,
  output logic       cycle_start,
  output logic [2:0] theta_idx,
  output logic       spike_out,
  output logic [7:0] actual_phase,
  output logic       fired,
  output logic       busy,
  output logic       done
);

  localparam int unsigned PW    = 8;
  localparam int unsigned IW    = 3;
  localparam int unsigned NSLOT = 8;

  localparam logic [PW-1:0] LAST_PHASE = PW'(255);
  localparam logic [IW-1:0] LAST_IDX   = IW'(7);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_d;

  logic [NSLOT-1:0][PW-1:0] slot_phase;
  logic [NSLOT-1:0]         slot_valid;

  logic [PW-1:0] snap_phase;
  logic [PW-1:0] snap_phase_d;
  logic          snap_valid;
  logic          snap_valid_d;
  logic          loop_q;
  logic          loop_d;
  logic          stop_pending;
  logic          stop_pending_d;

  logic [PW-1:0] global_phase_d;
  logic          cycle_start_d;
  logic [IW-1:0] theta_idx_d;
  logic          spike_d;
  logic [PW-1:0] actual_phase_d;
  logic          fired_d;
  logic          busy_d;
  logic          done_d;

  logic [IW-1:0] fetch_idx;
  logic [PW-1:0] fetch_phase;
  logic          fetch_valid;
  logic          fetch_spike;

  // Phase table; writes land one clock after wr_en, in any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_phase <= {NSLOT{INIT_PHASE}};
      slot_valid <= {NSLOT{INIT_VALID}};
    end else if (wr_en) begin
      slot_phase[wr_addr] <= wr_phase;
      slot_valid[wr_addr] <= wr_valid;
    end
  end

  // Slot for the gamma cycle about to begin. A write issued on the clock before
  // phase 0 is already part of the table at phase 0, so it is forwarded here.
  always_comb begin
    fetch_idx   = (state == RUN) ? theta_idx + IW'(1) : '0;
    fetch_phase = slot_phase[fetch_idx];
    fetch_valid = slot_valid[fetch_idx];
    if (wr_en && (wr_addr == fetch_idx)) begin
      fetch_phase = wr_phase;
      fetch_valid = wr_valid;
    end
    fetch_spike = fetch_valid && (fetch_phase == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      snap_phase   <= '0;
      snap_valid   <= 1'b0;
      loop_q       <= 1'b0;
      stop_pending <= 1'b0;
      global_phase <= '0;
      cycle_start  <= 1'b0;
      theta_idx    <= '0;
      spike_out    <= 1'b0;
      actual_phase <= '0;
      fired        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_d;
      snap_phase   <= snap_phase_d;
      snap_valid   <= snap_valid_d;
      loop_q       <= loop_d;
      stop_pending <= stop_pending_d;
      global_phase <= global_phase_d;
      cycle_start  <= cycle_start_d;
      theta_idx    <= theta_idx_d;
      spike_out    <= spike_d;
      actual_phase <= actual_phase_d;
      fired        <= fired_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

  always_comb begin
    state_d        = state;
    snap_phase_d   = snap_phase;
    snap_valid_d   = snap_valid;
    loop_d         = loop_q;
    stop_pending_d = stop_pending;
    global_phase_d = global_phase;
    cycle_start_d  = 1'b0;
    theta_idx_d    = theta_idx;
    spike_d        = 1'b0;
    actual_phase_d = actual_phase;
    fired_d        = fired;
    busy_d         = busy;
    done_d         = 1'b0;

    unique case (state)
      IDLE: begin
        global_phase_d = '0;
        theta_idx_d    = '0;
        actual_phase_d = '0;
        fired_d        = 1'b0;
        busy_d         = 1'b0;
        stop_pending_d = 1'b0;
        if (start) begin
          state_d        = RUN;
          busy_d         = 1'b1;
          loop_d         = loop_mode;
          snap_phase_d   = fetch_phase;
          snap_valid_d   = fetch_valid;
          spike_d        = fetch_spike;
          fired_d        = fetch_spike;
          actual_phase_d = fetch_spike ? fetch_phase : '0;
        end
      end

      RUN: begin
        if (stop) begin
          stop_pending_d = 1'b1;
        end
        if (global_phase == LAST_PHASE) begin
          // Termination only at the theta boundary keeps downstream theta counters aligned.
          if ((theta_idx == LAST_IDX) && (!loop_q || stop_pending)) begin
            state_d        = IDLE;
            done_d         = 1'b1;
            busy_d         = 1'b0;
            global_phase_d = '0;
            theta_idx_d    = '0;
            actual_phase_d = '0;
            fired_d        = 1'b0;
            stop_pending_d = 1'b0;
          end else begin
            global_phase_d = '0;
            theta_idx_d    = theta_idx + IW'(1);
            snap_phase_d   = fetch_phase;
            snap_valid_d   = fetch_valid;
            spike_d        = fetch_spike;
            fired_d        = fetch_spike;
            actual_phase_d = fetch_spike ? fetch_phase : '0;
          end
        end else begin
          global_phase_d = global_phase + PW'(1);
          cycle_start_d  = (global_phase_d == LAST_PHASE);
          spike_d        = snap_valid && (snap_phase == global_phase_d);
          if (spike_d) begin
            fired_d        = 1'b1;
            actual_phase_d = snap_phase;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_theta_phase_sequencer.sv
// Scoreboard bench for theta_phase_sequencer: stimulus pushes expected spikes,
// cycle_start records and done times; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_theta_phase_sequencer;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       start     = 1'b0;
  logic       stop      = 1'b0;
  logic       loop_mode = 1'b0;
  logic       wr_en     = 1'b0;
  logic [2:0] wr_addr   = 3'd0;
  logic [7:0] wr_phase  = 8'd0;
  logic       wr_valid  = 1'b0;

  logic [7:0] global_phase;
  logic       cycle_start;
  logic [2:0] theta_idx;
  logic       spike_out;
  logic [7:0] actual_phase;
  logic       fired;
  logic       busy;
  logic       done;

  theta_phase_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .loop_mode    (loop_mode),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_phase     (wr_phase),
    .wr_valid     (wr_valid),
    .global_phase (global_phase),
    .cycle_start  (cycle_start),
    .theta_idx    (theta_idx),
    .spike_out    (spike_out),
    .actual_phase (actual_phase),
    .fired        (fired),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] idx;
    logic       fired;
    logic [7:0] phase;
  } cyc_t;

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] phase;
  } spk_t;

  cyc_t cyc_q[$];
  spk_t spk_q[$];
  int   done_q[$];

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   last_cs  = -1;
  logic prev_cs  = 1'b0;
  cyc_t ce;
  spk_t se;

  logic [7:0] mdl_ph [8];
  logic       mdl_v  [8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares whenever the DUT presents spike_out, cycle_start or done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (spike_out) begin
        if (spk_q.size() == 0) chk("unexpected_spike", 1, 0);
        else begin
          se = spk_q.pop_front();
          chk("spike_theta", int'(theta_idx), int'(se.idx));
          chk("spike_phase", int'(global_phase), int'(se.phase));
        end
      end
      if (prev_cs) begin
        chk("fired_clear", int'(fired), 0);
        chk("actual_clear", int'(actual_phase), 0);
      end
      if (cycle_start) begin
        chk("cs_phase", int'(global_phase), 255);
        if (last_cs >= 0) chk("cs_spacing", cyc - last_cs, 256);
        last_cs = cyc;
        if (cyc_q.size() == 0) chk("unexpected_cs", 1, 0);
        else begin
          ce = cyc_q.pop_front();
          chk("cs_theta", int'(theta_idx), int'(ce.idx));
          chk("cs_fired", int'(fired), int'(ce.fired));
          chk("cs_actual", int'(actual_phase), int'(ce.phase));
        end
      end
      if (done) begin
        chk("done_busy", int'(busy), 0);
        last_cs = -1;
        if (done_q.size() == 0) chk("unexpected_done", 1, 0);
        else chk("done_time", cyc, done_q.pop_front());
      end
      prev_cs = cycle_start;
    end else begin
      prev_cs = 1'b0;
      last_cs = -1;
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_gp"},    int'(global_phase), 0);
    chk({tag, "_cs"},    int'(cycle_start), 0);
    chk({tag, "_theta"}, int'(theta_idx), 0);
    chk({tag, "_spike"}, int'(spike_out), 0);
    chk({tag, "_act"},   int'(actual_phase), 0);
    chk({tag, "_fired"}, int'(fired), 0);
    chk({tag, "_busy"},  int'(busy), 0);
    chk({tag, "_done"},  int'(done), 0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] p, input logic v);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_phase = p; wr_valid = v;
    mdl_ph[a] = p;
    mdl_v[a]  = v;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Expected spikes and cycle_start records for one theta pass of the model table.
  task automatic push_pass();
    cyc_t c;
    spk_t s;
    for (int i = 0; i < 8; i++) begin
      c.idx = 3'(i);
      s.idx = 3'(i);
      if (mdl_v[i]) begin
        s.phase = mdl_ph[i];
        spk_q.push_back(s);
        c.fired = 1'b1;
        c.phase = mdl_ph[i];
      end else begin
        c.fired = 1'b0;
        c.phase = 8'd0;
      end
      cyc_q.push_back(c);
    end
  endtask

  task automatic go(input logic lm, output int s);
    @(negedge clk);
    start = 1'b1; loop_mode = lm; s = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_until(input logic [2:0] t, input logic [7:0] p, input string name);
    int n = 0;
    while (!(theta_idx == t && global_phase == p) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(n < 5000), 1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", int'(n < budget), 1);
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("spk_q_empty", spk_q.size(), 0);
    chk("cyc_q_empty", cyc_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
  endtask

  initial begin
    int s;
    for (int i = 0; i < 8; i++) begin
      mdl_ph[i] = 8'd0;
      mdl_v[i]  = 1'b0;
    end

    // Reset state, and no activity one clock after release without start.
    repeat (3) @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_gp", int'(global_phase), 0);
    chk("post_rst_busy", int'(busy), 0);

    // One-shot playback of phases 10..80.
    for (int i = 0; i < 8; i++) wr(3'(i), 8'(10 * (i + 1)), 1'b1);
    push_pass();
    go(1'b0, s);
    done_q.push_back(s + 1 + 2048);
    @(negedge clk);
    chk("run_busy", int'(busy), 1);
    wait_done(3000);

    // Silent slot 3.
    wr(3'd3, 8'd40, 1'b0);
    push_pass();
    go(1'b0, s);
    done_q.push_back(s + 1 + 2048);
    wait_done(3000);

    // Boundary phases: spike on first RUN clock, and spike on cycle_start.
    wr(3'd0, 8'd0, 1'b1);
    wr(3'd1, 8'd255, 1'b1);
    wr(3'd3, 8'd40, 1'b1);
    push_pass();
    go(1'b0, s);
    done_q.push_back(s + 1 + 2048);
    wait_done(3000);

    // Loop mode: mid-cycle write to the active slot, ignored start/loop_mode, sticky stop.
    wr(3'd0, 8'd10, 1'b1);
    wr(3'd1, 8'd20, 1'b1);
    push_pass();
    go(1'b1, s);
    loop_mode = 1'b0;
    done_q.push_back(s + 1 + 4096);
    wait_until(3'd1, 8'd100, "reach_t1");
    pulse_start();
    wait_until(3'd2, 8'd5, "reach_t2");
    wr(3'd2, 8'd99, 1'b1);
    push_pass();
    while (cyc < s + 1 + 12 * 256 + 100) @(negedge clk);
    chk("stop_at_theta4", int'(theta_idx), 4);
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    wait_done(3000);

    // Stop in IDLE is ignored; then reset mid-run at theta 5, phase 130.
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    push_pass();
    go(1'b0, s);
    wait_until(3'd5, 8'd130, "reach_t5_p130");
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    spk_q.delete();
    cyc_q.delete();
    done_q.delete();
    for (int i = 0; i < 8; i++) begin
      mdl_ph[i] = 8'd0;
      mdl_v[i]  = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_pass();
    go(1'b0, s);
    done_q.push_back(s + 1 + 2048);
    wait_done(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
